daa_seq_multiplier: RTL and testbench
=====================================

# daa_seq_multiplier

Parametrised iterative shift-add multiplier, the successor of the combinational-per-clock 8×8 multiplier in the DAA datapath. Operands are captured on a start handshake and one multiplier bit is retired per clock. A one-cycle `done` pulse marks a held `result`. The block sits between the operand register file and the accumulator stage and trades latency for area, which suits the GDSII area budget.

## Interface
- `WIDTH`, default 8: operand width in bits; legal range 2–32.
- `clk` input 1: single clock, rising-edge.
- `reset_n` input 1: asynchronous active-low reset.
- `start` input 1: request a multiply; sampled only in IDLE.
- `a` input WIDTH: multiplicand; captured on accepted `start`.
- `b` input WIDTH: multiplier; captured on accepted `start`.
- `busy` output 1: high while an operation is in progress.
- `done` output 1: one-cycle pulse; `result` is valid from this cycle.
- `result` output 2*WIDTH: product; held until the next `done`.

## Operation
- **Reset.** When `reset_n`=0, asynchronously force:
  - state to IDLE;
  - `busy`=0, `done`=0, `result`=0;
  - the internal accumulator, operand registers and bit counter to 0.
- **IDLE.** `busy`=0.
  - `start`=1 at a rising edge: latch `a` and `b`, clear the 2*WIDTH accumulator, set the counter to 0, go to RUN.
  - `start`=0: stay in IDLE.
- **RUN.** `busy`=1. At each edge:
  - if bit `counter` of the latched b is 1, add (latched a << counter), zero-extended to 2*WIDTH, into the accumulator;
  - then increment the counter.
- **RUN exit.** On the edge that processes bit WIDTH-1:
  - `result` ← final accumulator value;
  - `done` ← 1, `busy` ← 0;
  - state ← IDLE.
- **`done` pulse.** `done` clears on the following edge unless another operation completes on that edge.
- **`start` while busy.** Ignored; it is neither queued nor latched.
- **Input changes.** Changes on `a`/`b` after capture have no effect on the operation in flight.
- **Zero operands.** An operand of 0 still takes the full WIDTH cycles; there is no early termination.
- **Back-to-back.** `start`=1 in the cycle `done`=1 is accepted, because the block is in IDLE. The previous `result` stays visible until the new `done`.
- **Arithmetic.** Unsigned and exact; 2*WIDTH bits cannot overflow. Intermediate sums are computed at 2*WIDTH+1 bits and the carry is discarded; it is always 0 in unsigned mode.
- **Reset mid-operation.** The operation is aborted, outputs return to reset values, and no `done` is issued.

## Timing
- Define edge k as the edge at which `start` is accepted.
- `busy`=1 from after edge k until edge k+WIDTH.
- `result` is updated and `done`=1 after edge k+WIDTH.
- Latency: WIDTH+1 edges from accepted `start` to `done`.
- Throughput: one product per WIDTH+1 cycles with back-to-back starts.
- `start`, `a` and `b` are sampled synchronously. The only asynchronous path is `reset_n`.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- **Macro `DAA_MULT_SIGNED_EN`.**
- **Defined.** `a`, `b` and `result` are two's complement.
  - The partial product for bit WIDTH-1 of b is subtracted instead of added.
  - Latched a is sign-extended to 2*WIDTH before shifting.
  - Latency and handshake are unchanged.
- **Undefined.** Unsigned operation as described above. No signed logic is synthesised.

## Test plan
- WIDTH=8, a=13, b=11, `start` one cycle → `done` exactly 9 edges later; `result`=143 (0x008F); `busy` high for 8 cycles.
- a=255, b=255 → `result`=65025 (0xFE01). Then a=0, b=200 → `result`=0 after a full 8-cycle latency.
- Start a=7, b=6. Re-assert `start` with a=3, b=3 at cycles 2–5 and change `a`/`b` → exactly one `done`; `result`=42.
- Back-to-back: `start` in the `done` cycle with a=2, b=100 → `result` reads 42 until the second `done`, then 200.
- Assert `reset_n`=0 for one cycle midway through an operation → immediately `busy`=0, `done`=0, `result`=0. No `done` follows; a new `start` then completes normally.
- With `DAA_MULT_SIGNED_EN`, WIDTH=8:
  - a=-3, b=5 → `result`=0xFFF1;
  - a=-128, b=-128 → `result`=16384 (0x4000);
  - a=127, b=-1 → `result`=0xFF81.

Source files
------------

// File: rtl/daa_seq_multiplier.sv
// daa_seq_multiplier: iterative shift-add multiplier, one multiplier bit retired per clock.
// Ports: clk, reset_n (async active-low), start (sampled in IDLE), a/b (WIDTH operands),
//        busy (operation in flight), done (one-cycle pulse), result (2*WIDTH product, held).
// Define DAA_MULT_SIGNED_EN for two's-complement operands and result.
module daa_seq_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   result
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] a_q, a_nx, b_q, b_nx;
  logic [2*WIDTH-1:0] acc, acc_nx, result_nx, a_ext, pp, sum;
  logic [CW-1:0] cnt, cnt_nx;
  logic done_nx, last, sub;
  assign last = cnt == CW'(WIDTH - 1);
`ifdef DAA_MULT_SIGNED_EN
  // The MSB of a two's-complement multiplier carries negative weight.
  assign a_ext = {{WIDTH{a_q[WIDTH-1]}}, a_q};
  assign sub   = last;
`else
  assign a_ext = {{WIDTH{1'b0}}, a_q};
  assign sub   = 1'b0;
`endif
  assign pp  = b_q[cnt] ? a_ext << cnt : '0;
  // Carry out of 2*WIDTH bits is discarded; it never affects the product.
  assign sum = sub ? acc - pp : acc + pp;
  assign busy = state == RUN;
  always_comb begin
    state_nx  = state;
    a_nx      = a_q;
    b_nx      = b_q;
    acc_nx    = acc;
    cnt_nx    = cnt;
    result_nx = result;
    done_nx   = 1'b0;
    if (state == IDLE) begin
      if (start) begin
        state_nx = RUN;
        a_nx     = a;
        b_nx     = b;
        acc_nx   = '0;
        cnt_nx   = '0;
      end
    end else begin
      acc_nx = sum;
      cnt_nx = cnt + 1'b1;
      if (last) begin
        state_nx  = IDLE;
        result_nx = sum;
        done_nx   = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      acc    <= '0;
      cnt    <= '0;
      result <= '0;
      done   <= 1'b0;
    end else begin
      state  <= state_nx;
      a_q    <= a_nx;
      b_q    <= b_nx;
      acc    <= acc_nx;
      cnt    <= cnt_nx;
      result <= result_nx;
      done   <= done_nx;
    end
  end
endmodule

// File: tb/tb_daa_seq_multiplier.sv
// tb_daa_seq_multiplier: directed vectors with a result/latency scoreboard for daa_seq_multiplier.
module tb_daa_seq_multiplier;
  localparam int W = 8;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic busy, done;
  logic [2*W-1:0] result;
  typedef struct {logic [2*W-1:0] r; int c;} exp_t;
  exp_t sb[$];
  int cyc = 0;
  int vectors = 0;
  int errors = 0;
  daa_seq_multiplier #(.WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .result(result)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // Monitor: every done pops one expected product and its expected completion cycle.
  always @(negedge clk) begin
    if (reset_n && done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", 32'(result), 32'(e.r));
        chk("latency_cycle", cyc, e.c);
        chk("busy_at_done", 32'(busy), 32'd0);
      end
    end
  end
  // Called at a negedge with the block idle (or showing done); returns just after the accepting edge.
  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic [2*W-1:0] r);
    start = 1'b1;
    a = x;
    b = y;
    @(posedge clk);
    #1;
    sb.push_back('{r, cyc + W});
    start = 1'b0;
  endtask
  task automatic wait_done();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 40);
    if (!done) chk("done_timeout", 32'd0, 32'd1);
  endtask
  initial begin
    int bc, n;
    repeat (2) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_result", 32'(result), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    issue(8'd13, 8'd11, 16'h008F);
    bc = 0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (busy) bc++;
    end while (!done && n < 40);
    chk("busy_cycles", bc, 32'd8);
    @(negedge clk);
`ifdef DAA_MULT_SIGNED_EN
    issue(8'hFF, 8'hFF, 16'h0001);
`else
    issue(8'hFF, 8'hFF, 16'hFE01);
`endif
    wait_done();
    @(negedge clk);
    issue(8'd0, 8'd200, 16'h0000);
    wait_done();
    @(negedge clk);
    issue(8'd7, 8'd6, 16'd42);
    @(negedge clk);
    for (int i = 2; i <= 5; i++) begin
      start = 1'b1;
      a = 8'd3;
      b = 8'd3;
      @(negedge clk);
    end
    start = 1'b0;
    a = 8'd99;
    b = 8'd77;
    wait_done();
    issue(8'd2, 8'd100, 16'd200);
    repeat (3) @(negedge clk);
    chk("result_hold", 32'(result), 32'd42);
    chk("busy_mid", 32'(busy), 32'd1);
    wait_done();
    @(negedge clk);
    chk("done_pulse", 32'(done), 32'd0);
    chk("result_held", 32'(result), 32'd200);
    issue(8'd13, 8'd11, 16'd143);
    repeat (4) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_result", 32'(result), 32'd0);
    sb.delete();
    @(negedge clk);
    reset_n = 1'b1;
    repeat (15) @(negedge clk);
    chk("no_done_after_abort", 32'(result), 32'd0);
    issue(8'd9, 8'd9, 16'd81);
    wait_done();
`ifdef DAA_MULT_SIGNED_EN
    @(negedge clk);
    issue(8'hFD, 8'd5, 16'hFFF1);
    wait_done();
    @(negedge clk);
    issue(8'h80, 8'h80, 16'h4000);
    wait_done();
    @(negedge clk);
    issue(8'h7F, 8'hFF, 16'hFF81);
    wait_done();
`endif
    @(negedge clk);
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
